// File: rtl/bp_cfg_regfile.sv
// Runtime config register file: active config index plus per-core freeze with staggered release.
// Latency: command accepted at edge t takes effect and raises resp_v_o from t+1; releases are stagger_cycles_p+1 apart.
// Backpressure: one-entry response buffer; cmd_ready_o stays low until the pending response is consumed with resp_yumi_i.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   cmd_v_i/cmd_w_i/cmd_addr_i/cmd_data_i/cmd_ready_o   command port (valid/ready)
//   resp_v_o/resp_data_o/resp_yumi_i                    response port (valid/yumi)
//   cfg_idx_o                 active aviary config index
//   freeze_o                  per-core freeze, 1 = frozen
//   busy_o                    staggered release in progress
module bp_cfg_regfile #(
  parameter int num_core_p       = 4,
  parameter int lg_max_cfgs_p    = 7,
  parameter int default_cfg_p    = 2,
  parameter int data_width_p     = 64,
  parameter int addr_width_p     = 16,
  parameter int stagger_cycles_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  input  logic                     cmd_w_i,
  input  logic [addr_width_p-1:0]  cmd_addr_i,
  input  logic [data_width_p-1:0]  cmd_data_i,
  output logic                     cmd_ready_o,
  output logic                     resp_v_o,
  output logic [data_width_p-1:0]  resp_data_o,
  input  logic                     resp_yumi_i,
  output logic [lg_max_cfgs_p-1:0] cfg_idx_o,
  output logic [num_core_p-1:0]    freeze_o,
  output logic                     busy_o
);

  localparam int cnt_w_lp = $clog2(stagger_cycles_p + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e                   state_q, state_n;
  logic [cnt_w_lp-1:0]      cnt_q, cnt_n;
  logic [lg_max_cfgs_p-1:0] cfg_q, cfg_n;
  logic [num_core_p-1:0]    freeze_q, freeze_n;
  logic [num_core_p-1:0]    pending_q, pending_n;
  logic                     err_q, err_n;
  logic                     resp_v_q, resp_v_n;
  logic [data_width_p-1:0]  resp_data_q, resp_data_n;

  logic                     accept;
  logic                     sel_cfg, sel_freeze, sel_status, sel_bcast;
  logic                     release_ok;
  logic [num_core_p-1:0]    rel_mask;
  logic [num_core_p-1:0]    freeze_f, pending_f;
  logic [num_core_p-1:0]    wmask;
  logic [data_width_p-1:0]  rdata;

  // Only the low bits of the write data are meaningful for any register.
  logic unused_data;
  assign unused_data = ^cmd_data_i;

  assign cmd_ready_o = ~resp_v_q & ~reset_i;
  assign accept      = cmd_v_i & cmd_ready_o;
  assign busy_o      = (state_q == S_WAIT) | (|pending_q);
  assign resp_v_o    = resp_v_q;
  assign resp_data_o = resp_data_q;
  assign cfg_idx_o   = cfg_q;
  assign freeze_o    = freeze_q;

  assign sel_cfg    = (cmd_addr_i == addr_width_p'('h00));
  assign sel_freeze = (cmd_addr_i == addr_width_p'('h08));
  assign sel_status = (cmd_addr_i == addr_width_p'('h10));
  assign sel_bcast  = (cmd_addr_i == addr_width_p'('h18));

  // Isolate the lowest set pending bit.
  assign rel_mask   = pending_q & (~pending_q + num_core_p'(1));
  // In WAIT, the cycle the counter reads zero doubles as an IDLE cycle so the
  // next release happens without an extra bubble.
  assign release_ok = (state_q == S_IDLE) | (cnt_q == '0);
  assign wmask      = cmd_data_i[num_core_p-1:0];

  always_comb begin
    // Release FSM first; the command path below overrides it so that a
    // simultaneous FREEZE write to the released core keeps it frozen.
    state_n   = state_q;
    cnt_n     = cnt_q;
    freeze_f  = freeze_q;
    pending_f = pending_q;
    if (release_ok) begin
      if (|pending_q) begin
        freeze_f  = freeze_q & ~rel_mask;
        pending_f = pending_q & ~rel_mask;
        cnt_n     = cnt_w_lp'(stagger_cycles_p);
        state_n   = S_WAIT;
      end else begin
        state_n   = S_IDLE;
      end
    end else begin
      cnt_n = cnt_q - 1'b1;
    end

    freeze_n    = freeze_f;
    pending_n   = pending_f;
    cfg_n       = cfg_q;
    err_n       = err_q;
    resp_v_n    = resp_v_q;
    resp_data_n = resp_data_q;
    rdata       = '0;

    if (resp_v_q & resp_yumi_i) begin
      resp_v_n = 1'b0;
    end

    if (accept) begin
      resp_v_n = 1'b1;
      if (cmd_w_i) begin
        resp_data_n = '0;
        if (sel_cfg) begin
          // Config may only change while every core is parked.
          if ((&freeze_q) & ~busy_o) begin
            cfg_n = cmd_data_i[lg_max_cfgs_p-1:0];
          end else begin
            err_n = 1'b1;
          end
        end
        if (sel_freeze) begin
          // 1s freeze and unqueue; 0s queue any core still frozen (a running
          // core is never pending, so OR-ing in freeze_f is enough).
          freeze_n  = freeze_f | wmask;
          pending_n = (pending_f | freeze_f) & ~wmask;
        end
        if (sel_bcast) begin
          if (cmd_data_i[0]) begin
            freeze_n  = '1;
            pending_n = '0;
          end else begin
            pending_n = pending_f | freeze_f;
          end
        end
      end else begin
        if (sel_cfg)    rdata = data_width_p'(cfg_q);
        if (sel_freeze) rdata = data_width_p'(freeze_q);
        if (sel_status) begin
          rdata = data_width_p'({err_q, busy_o});
          err_n = 1'b0;
        end
        resp_data_n = rdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cfg_q       <= lg_max_cfgs_p'(default_cfg_p);
      freeze_q    <= '1;
      pending_q   <= '0;
      err_q       <= 1'b0;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      cfg_q       <= cfg_n;
      freeze_q    <= freeze_n;
      pending_q   <= pending_n;
      err_q       <= err_n;
      resp_v_q    <= resp_v_n;
      resp_data_q <= resp_data_n;
    end
  end

endmodule

// File: tb/tb_bp_cfg_regfile.sv
// Directed bench for bp_cfg_regfile (4 cores, stagger 8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each scenario task performs its own comparisons.
module tb_bp_cfg_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_v = 1'b0;
  logic        cmd_w = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        cmd_ready;
  logic        resp_v;
  logic [63:0] resp_data;
  logic        resp_yumi = 1'b0;
  logic [6:0]  cfg_idx;
  logic [3:0]  freeze;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bp_cfg_regfile #(
    .num_core_p(4), .lg_max_cfgs_p(7), .default_cfg_p(2),
    .data_width_p(64), .addr_width_p(16), .stagger_cycles_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_v_i(cmd_v), .cmd_w_i(cmd_w), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .cmd_ready_o(cmd_ready),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_yumi_i(resp_yumi),
    .cfg_idx_o(cfg_idx), .freeze_o(freeze), .busy_o(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until the edge that accepts it.
  task automatic send(input logic w, input logic [15:0] a, input logic [63:0] d);
    int n;
    n = 0;
    cmd_v = 1'b1; cmd_w = w; cmd_addr = a; cmd_data = d;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready addr=%h got %b required 1", a, cmd_ready);
    end
    tick;
    cmd_v = 1'b0;
  endtask

  // Consume the buffered response.
  task automatic take(output logic [63:0] d);
    vectors++;
    if (resp_v !== 1'b1) begin
      miscompares++;
      $display("FAIL take_resp_v got %b required 1", resp_v);
    end
    d = resp_data;
    resp_yumi = 1'b1;
    tick;
    resp_yumi = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick;
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle busy got %b required 0", busy);
    end
  endtask

  task automatic test_reset;
    logic [63:0] rd;
    reset = 1'b1;
    repeat (3) tick;
    vectors += 6;
    if (freeze !== 4'hF) begin miscompares++; $display("FAIL rst_freeze got %h required f", freeze); end
    if (cfg_idx !== 7'd2) begin miscompares++; $display("FAIL rst_cfg got %0d required 2", cfg_idx); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b required 0", busy); end
    if (resp_v !== 1'b0) begin miscompares++; $display("FAIL rst_resp_v got %b required 0", resp_v); end
    if (resp_data !== 64'h0) begin miscompares++; $display("FAIL rst_resp_data got %h required 0", resp_data); end
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready got %b required 0", cmd_ready); end
    reset = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready got %b required 1", cmd_ready); end
    send(1'b0, 16'h10, 64'h0); take(rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL rst_rd_status got %h required 0", rd); end
    send(1'b0, 16'h08, 64'h0); take(rd);
    vectors++;
    if (rd !== 64'hF) begin miscompares++; $display("FAIL rst_rd_freeze got %h required f", rd); end
    send(1'b0, 16'h00, 64'h0); take(rd);
    vectors++;
    if (rd !== 64'h2) begin miscompares++; $display("FAIL rst_rd_cfg got %h required 2", rd); end
  endtask

  task automatic test_cfg_write;
    logic [63:0] rd;
    send(1'b1, 16'h00, 64'h9); take(rd);
    vectors += 2;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL cfgw_ack got %h required 0", rd); end
    if (cfg_idx !== 7'd9) begin miscompares++; $display("FAIL cfgw_apply got %0d required 9", cfg_idx); end
    send(1'b0, 16'h00, 64'h0); take(rd);
    vectors++;
    if (rd !== 64'h9) begin miscompares++; $display("FAIL cfgw_readback got %h required 9", rd); end
    send(1'b1, 16'h00, 64'h2); take(rd);
    send(1'b0, 16'h10, 64'h0); take(rd);
    vectors += 2;
    if (cfg_idx !== 7'd2) begin miscompares++; $display("FAIL cfgw_restore got %0d required 2", cfg_idx); end
    if (rd !== 64'h0) begin miscompares++; $display("FAIL cfgw_no_err got %h required 0", rd); end
  endtask

  task automatic test_release;
    logic [63:0] rd;
    logic [3:0]  exp_prev, exp_next;
    send(1'b1, 16'h18, 64'h0);
    vectors += 2;
    if (freeze !== 4'hF) begin miscompares++; $display("FAIL rel_pending_freeze got %h required f", freeze); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL rel_pending_busy got %b required 1", busy); end
    take(rd);
    vectors += 2;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL rel_ack got %h required 0", rd); end
    if (freeze !== 4'hE) begin miscompares++; $display("FAIL rel_step1 got %h required e", freeze); end
    for (int s = 2; s < 5; s++) begin
      exp_prev = 4'hF << (s - 1);
      exp_next = 4'hF << s;
      repeat (8) tick;
      vectors++;
      if (freeze !== exp_prev) begin miscompares++; $display("FAIL rel_hold%0d got %h required %h", s, freeze, exp_prev); end
      tick;
      vectors++;
      if (freeze !== exp_next) begin miscompares++; $display("FAIL rel_step%0d got %h required %h", s, freeze, exp_next); end
    end
    repeat (8) tick;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL rel_last_wait got %b required 1", busy); end
    tick;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rel_done_busy got %b required 0", busy); end
  endtask

  task automatic test_cfg_err;
    logic [63:0] rd;
    send(1'b1, 16'h00, 64'h5); take(rd);
    vectors += 2;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL err_ack got %h required 0", rd); end
    if (cfg_idx !== 7'd2) begin miscompares++; $display("FAIL err_cfg_kept got %0d required 2", cfg_idx); end
    send(1'b0, 16'h10, 64'h0); take(rd);
    vectors++;
    if (rd !== 64'h2) begin miscompares++; $display("FAIL err_status1 got %h required 2", rd); end
    send(1'b0, 16'h10, 64'h0); take(rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL err_status2 got %h required 0", rd); end
    send(1'b0, 16'h08, 64'h0); take(rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL err_rd_freeze got %h required 0", rd); end
  endtask

  task automatic test_freeze_abort;
    logic [63:0] rd;
    send(1'b1, 16'h18, 64'h1); take(rd);
    vectors += 2;
    if (freeze !== 4'hF) begin miscompares++; $display("FAIL abort_bcast1 got %h required f", freeze); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_bcast1_busy got %b required 0", busy); end
    send(1'b1, 16'h18, 64'h0); take(rd);
    vectors++;
    if (freeze !== 4'hE) begin miscompares++; $display("FAIL abort_core0 got %h required e", freeze); end
    send(1'b1, 16'h08, 64'hF);
    vectors += 2;
    if (freeze !== 4'hF) begin miscompares++; $display("FAIL abort_refreeze got %h required f", freeze); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_wait_busy got %b required 1", busy); end
    take(rd);
    repeat (6) tick;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_gap_kept got %b required 1", busy); end
    tick;
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_gap_end got %b required 0", busy); end
    if (freeze !== 4'hF) begin miscompares++; $display("FAIL abort_final got %h required f", freeze); end
  endtask

  // FREEZE write lands on the same edge the FSM releases core 1.
  task automatic test_collision;
    logic [63:0] rd;
    send(1'b1, 16'h08, 64'hC); take(rd);
    vectors++;
    if (freeze !== 4'hE) begin miscompares++; $display("FAIL coll_core0 got %h required e", freeze); end
    repeat (8) tick;
    send(1'b1, 16'h08, 64'hE);
    vectors++;
    if (freeze !== 4'hE) begin miscompares++; $display("FAIL coll_write_wins got %h required e", freeze); end
    take(rd);
    wait_idle;
    vectors++;
    if (freeze !== 4'hE) begin miscompares++; $display("FAIL coll_settled got %h required e", freeze); end
  endtask

  task automatic test_backpressure;
    logic [63:0] rd;
    send(1'b0, 16'h00, 64'h0);
    cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = 16'h08; cmd_data = '0;
    for (int i = 0; i < 5; i++) begin
      vectors += 3;
      if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready%0d got %b required 0", i, cmd_ready); end
      if (resp_v !== 1'b1) begin miscompares++; $display("FAIL bp_resp_v%0d got %b required 1", i, resp_v); end
      if (resp_data !== 64'h2) begin miscompares++; $display("FAIL bp_data%0d got %h required 2", i, resp_data); end
      tick;
    end
    resp_yumi = 1'b1;
    tick;
    resp_yumi = 1'b0;
    vectors += 2;
    if (resp_v !== 1'b0) begin miscompares++; $display("FAIL bp_drained got %b required 0", resp_v); end
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back got %b required 1", cmd_ready); end
    tick;
    cmd_v = 1'b0;
    vectors += 2;
    if (resp_v !== 1'b1) begin miscompares++; $display("FAIL bp_second_v got %b required 1", resp_v); end
    if (resp_data !== 64'hE) begin miscompares++; $display("FAIL bp_second_data got %h required e", resp_data); end
    take(rd);
    vectors++;
    if (resp_v !== 1'b0) begin miscompares++; $display("FAIL bp_single_accept got %b required 0", resp_v); end
  endtask

  task automatic test_unmapped;
    logic [63:0] rd;
    send(1'b0, 16'h20, 64'h0); take(rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL unm_read got %h required 0", rd); end
    send(1'b1, 16'h20, 64'hFFFF_FFFF_FFFF_FFFF); take(rd);
    vectors += 2;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL unm_write_ack got %h required 0", rd); end
    if (freeze !== 4'hE) begin miscompares++; $display("FAIL unm_no_effect got %h required e", freeze); end
    send(1'b0, 16'h18, 64'h0); take(rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL unm_bcast_read got %h required 0", rd); end
  endtask

  task automatic test_mid_reset;
    logic [63:0] rd;
    send(1'b1, 16'h18, 64'h1); take(rd);
    send(1'b1, 16'h00, 64'h9); take(rd);
    vectors++;
    if (cfg_idx !== 7'd9) begin miscompares++; $display("FAIL mrst_cfg_set got %0d required 9", cfg_idx); end
    send(1'b1, 16'h18, 64'h0); take(rd);
    repeat (12) tick;
    vectors += 2;
    if (freeze !== 4'hC) begin miscompares++; $display("FAIL mrst_midway got %h required c", freeze); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL mrst_midway_busy got %b required 1", busy); end
    reset = 1'b1;
    tick;
    vectors += 4;
    if (freeze !== 4'hF) begin miscompares++; $display("FAIL mrst_freeze got %h required f", freeze); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL mrst_busy got %b required 0", busy); end
    if (cfg_idx !== 7'd2) begin miscompares++; $display("FAIL mrst_cfg got %0d required 2", cfg_idx); end
    if (resp_v !== 1'b0) begin miscompares++; $display("FAIL mrst_resp_v got %b required 0", resp_v); end
    reset = 1'b0;
    repeat (12) tick;
    vectors += 2;
    if (freeze !== 4'hF) begin miscompares++; $display("FAIL mrst_no_resume got %h required f", freeze); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL mrst_idle got %b required 0", busy); end
  endtask

  initial begin
    #1;
    test_reset;
    test_cfg_write;
    test_release;
    test_cfg_err;
    test_freeze_abort;
    test_collision;
    test_backpressure;
    test_unmapped;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
